// File: rtl/niosii_system_sysid_checker.sv
// niosii_system_sysid_checker
// Avalon-MM master that reads the system-ID slave (word 0 = ID, word 1 = build
// timestamp), compares both words against build-time constants and reports
// registered pass/fail status together with the captured words. A check runs
// automatically after reset (AUTO_START) or whenever start is pulsed while idle.
// Each read is guarded by a waitrequest stall counter; a stuck slave aborts the
// check with timeout=1 and both compare results forced low.

module niosii_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1487976229,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_ID = 2'd1,
    ST_RD_TS = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Stall limit in the counter's own width; legal range is 1..65535.
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state_r;
  logic        auto_pend_r;
  logic [15:0] stall_cnt_r;
  logic [15:0] stall_cnt_inc_s;
  logic        stall_s;
  logic        limit_hit_s;
  logic        launch_s;

  // Full-width equality of a captured word against its expected constant.
  function automatic logic word_match(input logic [31:0] captured,
                                      input logic [31:0] expected);
    return (captured == expected);
  endfunction

  // Stall detection, saturating counter increment and check-launch decode.
  always_comb begin
    stall_s = avm_read && avm_waitrequest;
    if (stall_cnt_r == 16'hFFFF) begin
      stall_cnt_inc_s = stall_cnt_r;
    end else begin
      stall_cnt_inc_s = stall_cnt_r + 16'd1;
    end
    if (stall_s) begin
      limit_hit_s = (stall_cnt_inc_s >= TIMEOUT_LIMIT);
    end else begin
      limit_hit_s = 1'b0;
    end
    if (state_r == ST_IDLE) begin
      launch_s = start || auto_pend_r;
    end else begin
      launch_s = 1'b0;
    end
  end

  // Check sequencer: issues the two reads, captures data, applies the stall
  // timeout and registers every status output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      auto_pend_r <= AUTO_START;
      stall_cnt_r <= 16'd0;
      avm_address <= 1'b0;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= 32'h0000_0000;
      ts_value    <= 32'h0000_0000;
    end else begin
      // The auto-start request only lives for the first clock after reset.
      auto_pend_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (launch_s) begin
            state_r     <= ST_RD_ID;
            stall_cnt_r <= 16'd0;
            avm_address <= 1'b0;
            avm_read    <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
          end else begin
            avm_read <= 1'b0;
            busy     <= 1'b0;
          end
        end
        ST_RD_ID: begin
          if (!avm_waitrequest) begin
            id_value    <= avm_readdata;
            avm_address <= 1'b1;
            stall_cnt_r <= 16'd0;
            state_r     <= ST_RD_TS;
          end else if (limit_hit_s) begin
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            timeout     <= 1'b1;
            stall_cnt_r <= 16'd0;
            state_r     <= ST_FIN;
          end else begin
            stall_cnt_r <= stall_cnt_inc_s;
          end
        end
        ST_RD_TS: begin
          if (!avm_waitrequest) begin
            ts_value    <= avm_readdata;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            stall_cnt_r <= 16'd0;
            state_r     <= ST_FIN;
          end else if (limit_hit_s) begin
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            timeout     <= 1'b1;
            stall_cnt_r <= 16'd0;
            state_r     <= ST_FIN;
          end else begin
            stall_cnt_r <= stall_cnt_inc_s;
          end
        end
        ST_FIN: begin
          // A timed-out check never reports a pass, whatever was captured.
          id_ok       <= !timeout && word_match(id_value, EXPECTED_ID);
          ts_ok       <= !timeout && word_match(ts_value, EXPECTED_TS);
          done        <= 1'b1;
          busy        <= 1'b0;
          avm_read    <= 1'b0;
          stall_cnt_r <= 16'd0;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          avm_read    <= 1'b0;
          avm_address <= 1'b0;
          busy        <= 1'b0;
          stall_cnt_r <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Testbench for niosii_system_sysid_checker: behavioural Avalon slave with a
// programmable stall count, table of directed vectors plus randomized vectors
// whose expectations come from a timing/result model of the check, and
// hand-written reset sequences.

module tb_niosii_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1487976229;
  localparam int          TO     = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  niosii_system_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
    .TIMEOUT_CYCLES(TO), .AUTO_START(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  // Behavioural slave: each read stalls stall_cfg cycles, then returns mem[addr].
  logic [31:0] mem [0:1];
  int          stall_cfg = 0;
  int          stall_ctr = 0;
  assign avm_waitrequest = avm_read && (stall_ctr < stall_cfg);
  assign avm_readdata    = avm_read ? mem[avm_address] : 32'hDEAD_BEEF;

  always @(posedge clock) begin
    if (avm_read && avm_waitrequest) stall_ctr <= stall_ctr + 1;
    else                             stall_ctr <= 0;
  end

  // Bus monitor: accepted reads, stall-run lengths, stability during stalls.
  int   reads = 0, cur_run = 0, last_run = 0, stab_err = 0;
  logic last_stall = 1'b0, last_addr = 1'b0;
  always @(posedge clock) begin
    if (reset) begin
      cur_run    <= 0;
      last_stall <= 1'b0;
    end else begin
      last_stall <= avm_read && avm_waitrequest;
      last_addr  <= avm_address;
      if (last_stall && avm_read && (avm_address != last_addr)) stab_err <= stab_err + 1;
      if (last_stall && !avm_read && (cur_run < TO))            stab_err <= stab_err + 1;
      if (avm_read && avm_waitrequest) begin
        cur_run <= cur_run + 1;
      end else begin
        if (cur_run != 0) last_run <= cur_run;
        cur_run <= 0;
      end
      if (avm_read && !avm_waitrequest) reads <= reads + 1;
    end
  end

  typedef struct {
    logic [31:0] id_w;
    logic [31:0] ts_w;
    int          stall;
    int          extra_start;
    bit          exp_id_ok;
    bit          exp_ts_ok;
    bit          exp_to;
    int          exp_lat;
  } vec_t;

  int          n_cmp = 0, n_err = 0;
  logic [31:0] prev_id = 32'h0, prev_ts = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a read completes after its stalls + 1 cycle; hitting TO stalls
  // aborts; the rest of the check is one FIN cycle and one cycle to see done.
  function automatic vec_t model(input logic [31:0] id_w, input logic [31:0] ts_w,
                                 input int stall);
    vec_t v;
    v.id_w = id_w; v.ts_w = ts_w; v.stall = stall; v.extra_start = 0;
    if (stall >= TO) begin
      v.exp_to = 1'b1; v.exp_id_ok = 1'b0; v.exp_ts_ok = 1'b0;
      v.exp_lat = TO + 2;
    end else begin
      v.exp_to = 1'b0;
      v.exp_id_ok = (id_w == EXP_ID);
      v.exp_ts_ok = (ts_w == EXP_TS);
      v.exp_lat = 2 * (stall + 1) + 2;
    end
    return v;
  endfunction

  // Wait (bounded) for done from the current cycle; returns cycle count.
  task automatic wait_done(input int extra_start, inout int cyc);
    while (!done && cyc < 200) begin
      start = (cyc == extra_start) ? 1'b1 : 1'b0;
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int          cyc, r0;
    logic [31:0] e_id, e_ts;
    mem[0] = v.id_w; mem[1] = v.ts_w; stall_cfg = v.stall;
    r0 = reads;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0; cyc = 1;
    check("done_cleared_on_start", {31'd0, done}, 32'd0);
    check("busy_on_start", {31'd0, busy}, 32'd1);
    wait_done(v.extra_start, cyc);
    e_id = v.exp_to ? prev_id : v.id_w;
    e_ts = v.exp_to ? prev_ts : v.ts_w;
    check("latency", cyc, v.exp_lat);
    check("id_ok", {31'd0, id_ok}, {31'd0, v.exp_id_ok});
    check("ts_ok", {31'd0, ts_ok}, {31'd0, v.exp_ts_ok});
    check("timeout", {31'd0, timeout}, {31'd0, v.exp_to});
    check("id_value", id_value, e_id);
    check("ts_value", ts_value, e_ts);
    check("reads", reads - r0, v.exp_to ? 32'd0 : 32'd2);
    if (v.exp_to) check("stall_run_at_timeout", last_run, TO);
    else if (v.stall > 0) check("stall_run", last_run, v.stall);
    repeat (2) @(negedge clock);
    check("idle_after_done", {30'd0, busy, done}, 32'd1);
    prev_id = e_id; prev_ts = e_ts;
  endtask

  vec_t tbl [9];

  initial begin
    #400000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int   cyc;
    vec_t rv;
    tbl[0] = '{32'h0, EXP_TS, 0, 0, 1'b1, 1'b1, 1'b0, 4};
    tbl[1] = '{32'h0, 32'h5AB0_0000, 0, 0, 1'b1, 1'b0, 1'b0, 4};
    tbl[2] = '{32'h0, EXP_TS, 3, 0, 1'b1, 1'b1, 1'b0, 10};
    tbl[3] = '{32'h0, EXP_TS, 1000, 0, 1'b0, 1'b0, 1'b1, 10};
    tbl[4] = '{32'h0, EXP_TS, 0, 2, 1'b1, 1'b1, 1'b0, 4};
    tbl[5] = '{32'h1, EXP_TS, 7, 0, 1'b0, 1'b1, 1'b0, 18};
    tbl[6] = '{32'h0, EXP_TS, 8, 0, 1'b0, 1'b0, 1'b1, 10};
    tbl[7] = '{32'h0, 32'd1487976228, 1, 0, 1'b1, 1'b0, 1'b0, 6};
    tbl[8] = '{32'hFFFF_FFFF, 32'h5AB0_0000, 0, 3, 1'b0, 1'b0, 1'b0, 4};

    // Reset state, then auto-start against a correct slave.
    mem[0] = EXP_ID; mem[1] = EXP_TS; stall_cfg = 0;
    repeat (3) @(negedge clock);
    check("reset_outputs", {avm_read, busy, done, id_ok, ts_ok, timeout}, 32'd0);
    check("reset_values", id_value | ts_value, 32'd0);
    reset = 1'b0; cyc = 0;
    wait_done(-1, cyc);
    check("auto_start_latency", cyc, 4);
    check("auto_start_result", {29'd0, id_ok, ts_ok, timeout}, 32'd6);
    prev_id = EXP_ID; prev_ts = EXP_TS;

    // Directed vectors.
    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Reset during RD_TS aborts at once; no read while reset is high.
    mem[0] = EXP_ID; mem[1] = EXP_TS; stall_cfg = 2;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (3) @(negedge clock);
    check("in_rd_ts_before_reset", {30'd0, avm_read, avm_address}, 32'd3);
    #2 reset = 1'b1;
    #1 check("async_reset_outputs", {avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}, 32'd0);
    check("async_reset_values", id_value | ts_value, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("no_read_in_reset", {31'd0, avm_read}, 32'd0);
    end
    stall_cfg = 0;
    reset = 1'b0; cyc = 0;
    wait_done(-1, cyc);
    check("rerun_after_reset_latency", cyc, 4);
    check("rerun_after_reset_result", {29'd0, id_ok, ts_ok, timeout}, 32'd6);
    prev_id = EXP_ID; prev_ts = EXP_TS;

    // Randomized vectors checked against the model.
    for (int i = 0; i < 14; i++) begin
      logic [31:0] rid, rts;
      int          rst_stall;
      rid = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
      rts = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
      rst_stall = ($urandom_range(0, 4) == 0) ? int'($urandom_range(8, 12))
                                              : int'($urandom_range(0, 6));
      rv = model(rid, rts, rst_stall);
      run_vec(rv);
    end

    check("addr_read_stable_during_stall", stab_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
